half_adder: RTL and testbench
=============================

# half_adder

Registered, multi-lane half adder. Each lane adds two 1-bit operands and produces a sum bit and a carry bit, with one clock cycle of latency and a valid qualifier. The block is the leaf arithmetic primitive used by wider adders and counters in the datapath. An optional carry-statistics counter is compiled in by macro.

## Interface
Parameters:
- WIDTH, default 1: number of independent 1-bit lanes; legal range 1..64.
- CNT_W, default 16: width of the carry-statistics counter; legal range 8..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-high; clears all state immediately.
- in_valid  input  1  qualifies a/b; a sample is accepted on each rising clk edge where in_valid=1.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- out_valid  output  1  high for one cycle per accepted sample.
- s  output  WIDTH  registered sum, per lane a^b.
- c  output  WIDTH  registered carry, per lane a&b.
- stats_clr  input  1  synchronous clear of carry_cnt. Present only with HALF_ADDER_STATS_EN.
- carry_cnt  output  CNT_W  saturating count of carry bits generated. Present only with HALF_ADDER_STATS_EN.

## Operation
- Per lane i: s[i]=a[i] XOR b[i]; c[i]=a[i] AND b[i]. Lanes never interact, and there is no carry propagation between lanes.
- Truth table per lane (a,b -> s,c): 00->00, 01->10, 10->10, 11->01.
- Accepted sample (in_valid=1 at edge): s and c are loaded, and out_valid<=1.
- No sample (in_valid=0): out_valid<=0. s and c hold their last values; they do not return to 0.
- No backpressure: every valid sample is accepted, and throughput is one sample per cycle.
- X on a/b while in_valid=0 must not propagate into s/c.
- Carry statistics (macro on): on each accepted sample, carry_cnt += popcount(a&b) over all lanes.
  - carry_cnt saturates at 2^CNT_W-1 and never wraps.
  - stats_clr=1 sets carry_cnt to 0 at the next edge. When stats_clr and an accepted sample coincide, the clear wins and that sample's carries are discarded.

## Timing
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on s/c/out_valid after edge N.
- Back-to-back samples on consecutive cycles produce back-to-back out_valid pulses with correct per-cycle data.
- Reset values: s=0, c=0, out_valid=0, carry_cnt=0.
- Reset is asynchronous and acts mid-operation: asserting rst clears all outputs without a clock edge.
  - A sample presented in the same cycle rst deasserts is ignored if rst is still high at that edge.
  - The first sample is accepted at the first rising edge with rst=0.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- HALF_ADDER_STATS_EN defined: stats_clr port, carry_cnt port and the counter logic are present, with behaviour as in Operation.
- HALF_ADDER_STATS_EN undefined: those ports and the counter are absent. The sum, carry and valid behaviour and timing are identical in both builds.

## Test plan
- Truth table, WIDTH=1: apply (a,b)=00,01,10,11 with in_valid=1, holding each for 100 ns. One cycle later each must give (s,c)=00,10,10,01, with out_valid=1 each cycle.
- Hold and valid: accept a=1,b=1, then drive in_valid=0 with a=0,b=1. Required: out_valid drops to 0, and s=0,c=1 hold.
- Async reset: with s=1, assert rst between clock edges. Required: s, c and out_valid go to 0 immediately. After rst drops, the first edge with in_valid=1, a=1, b=0 gives s=1, c=0.
- Multi-lane, WIDTH=8: a=0xF0, b=0x3C. Required: s=0xCC, c=0x30, with no interaction between lanes.
- Stats (macro on, WIDTH=8, CNT_W=8):
  - 3 accepted samples of a=b=0xFF give carry_cnt=24.
  - Asserting stats_clr together with a sample of a=b=0xFF gives carry_cnt=0.
  - 40 samples of a=b=0xFF saturate carry_cnt at 255.
- Back-to-back: 4 consecutive valid samples 00,01,10,11 give 4 consecutive out_valid pulses with (s,c)=00,10,10,01 in order.

Source files
------------

// File: rtl/half_adder.sv
`timescale 1ns/1ps
// half_adder: registered per-lane half adder (s=a^b, c=a&b), optional carry counter under HALF_ADDER_STATS_EN.
// Latency: 1 cycle from an accepted sample (in_valid=1 at the edge) to s/c/out_valid.
// Backpressure: none; one sample accepted every cycle, s/c hold their value on idle cycles.
module half_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef HALF_ADDER_STATS_EN
  input  logic             stats_clr,
  output logic [CNT_W-1:0] carry_cnt,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c
);

  // Reject out-of-range parameters at elaboration
  if (WIDTH < 1 || WIDTH > 64 || CNT_W < 8 || CNT_W > 32) begin : g_bad_params
    $error("half_adder: WIDTH must be 1..64 and CNT_W 8..32");
  end

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] s_d, s_q;
  logic [WIDTH-1:0] c_d, c_q;

  // Load sum/carry only on accepted samples, so idle-cycle X on a/b never reaches s/c
  always_comb begin
    out_valid_d = in_valid;
    s_d         = s_q;
    c_d         = c_q;
    if (in_valid) begin
      s_d = a ^ b;
      c_d = a & b;
    end
  end

  // Output registers, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      c_q         <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      c_q         <= c_d;
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign c         = c_q;

`ifdef HALF_ADDER_STATS_EN
  localparam int PC_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic [PC_W-1:0]  carry_pop;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Number of lanes generating a carry in the incoming sample
  always_comb begin
    carry_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      carry_pop = carry_pop + PC_W'(a[i] & b[i]);
    end
  end

  // Saturating accumulate; a clear beats a coincident sample and discards its carries
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + (CNT_W + 1)'(carry_pop);
    cnt_d   = cnt_q;
    if (stats_clr) begin
      cnt_d = '0;
    end else if (in_valid) begin
      cnt_d = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
  end

  // Counter register, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign carry_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_half_adder.sv
`timescale 1ns/1ps
// Testbench for half_adder: a 1-lane and an 8-lane instance driven together, checked against a lane-arithmetic model.
module tb_half_adder;

  logic       clk;
  logic       rst;
  logic       iv;
  logic       clr;
  logic       a1, b1;
  logic [7:0] a8, b8;

  logic        v1, s1, c1;
  logic        v8;
  logic [7:0]  s8, c8;
  logic [15:0] cnt1;
  logic [7:0]  cnt8;

  int checks = 0;
  int errors = 0;

  // Reference state, updated from the lane arithmetic a+b = 2*carry + sum
  logic       m_v;
  logic       m_s1, m_c1;
  logic [7:0] m_s8, m_c8;
  int         m_cnt1, m_cnt8;

  half_adder #(.WIDTH(1)) u_n1 (
    .clk(clk), .rst(rst), .in_valid(iv), .a(a1), .b(b1),
`ifdef HALF_ADDER_STATS_EN
    .stats_clr(clr), .carry_cnt(cnt1),
`endif
    .out_valid(v1), .s(s1), .c(c1)
  );

  half_adder #(.WIDTH(8), .CNT_W(8)) u_n8 (
    .clk(clk), .rst(rst), .in_valid(iv), .a(a8), .b(b8),
`ifdef HALF_ADDER_STATS_EN
    .stats_clr(clr), .carry_cnt(cnt8),
`endif
    .out_valid(v8), .s(s8), .c(c8)
  );

`ifndef HALF_ADDER_STATS_EN
  assign cnt1 = '0;
  assign cnt8 = '0;
`endif

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    m_v = 1'b0; m_s1 = 1'b0; m_c1 = 1'b0; m_s8 = '0; m_c8 = '0;
    m_cnt1 = 0; m_cnt8 = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_edge();
    int t;
    int carries8;
    int carries1;
    if (rst) begin
      model_zero();
    end else begin
      carries8 = 0;
      carries1 = 0;
      m_v = iv;
      if (iv) begin
        for (int i = 0; i < 8; i++) begin
          t = int'(a8[i]) + int'(b8[i]);
          m_s8[i] = (t % 2) != 0;
          m_c8[i] = (t / 2) != 0;
          carries8 += t / 2;
        end
        t = int'(a1) + int'(b1);
        m_s1 = (t % 2) != 0;
        m_c1 = (t / 2) != 0;
        carries1 = t / 2;
      end
      if (clr) begin
        m_cnt1 = 0;
        m_cnt8 = 0;
      end else if (iv) begin
        m_cnt1 = (m_cnt1 + carries1 > 65535) ? 65535 : m_cnt1 + carries1;
        m_cnt8 = (m_cnt8 + carries8 > 255) ? 255 : m_cnt8 + carries8;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".v1"}, 32'(v1), 32'(m_v));
    check({tag, ".s1"}, 32'(s1), 32'(m_s1));
    check({tag, ".c1"}, 32'(c1), 32'(m_c1));
    check({tag, ".v8"}, 32'(v8), 32'(m_v));
    check({tag, ".s8"}, 32'(s8), 32'(m_s8));
    check({tag, ".c8"}, 32'(c8), 32'(m_c8));
`ifdef HALF_ADDER_STATS_EN
    check({tag, ".cnt1"}, 32'(cnt1), 32'(m_cnt1));
    check({tag, ".cnt8"}, 32'(cnt8), 32'(m_cnt8));
`endif
  endtask

  // One clock: model the edge, let it happen, sample 1 ns later
  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  typedef struct {
    logic a;
    logic b;
    logic es;
    logic ec;
  } tt_t;

  tt_t tt[4];

  initial begin
    tt[0] = '{a: 1'b0, b: 1'b0, es: 1'b0, ec: 1'b0};
    tt[1] = '{a: 1'b0, b: 1'b1, es: 1'b1, ec: 1'b0};
    tt[2] = '{a: 1'b1, b: 1'b0, es: 1'b1, ec: 1'b0};
    tt[3] = '{a: 1'b1, b: 1'b1, es: 1'b0, ec: 1'b1};

    rst = 1'b1; iv = 1'b0; clr = 1'b0;
    a1 = 1'b0; b1 = 1'b0; a8 = '0; b8 = '0;
    model_zero();

    // Reset state
    cycle("reset");
    cycle("reset");
    check("reset_v", 32'(v8), 32'd0);
    check("reset_s", 32'(s8), 32'd0);
    rst = 1'b0;

    // Truth table, one sample per cycle (also back-to-back)
    for (int i = 0; i < 4; i++) begin
      iv = 1'b1; a1 = tt[i].a; b1 = tt[i].b;
      a8 = {8{tt[i].a}}; b8 = {8{tt[i].b}};
      cycle("tt");
      check("tt_s1", 32'(s1), 32'(tt[i].es));
      check("tt_c1", 32'(c1), 32'(tt[i].ec));
      check("tt_v1", 32'(v1), 32'd1);
    end

    // Hold: out_valid drops, s/c keep the last accepted result
    iv = 1'b1; a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    cycle("hold_load");
    iv = 1'b0; a1 = 1'b0; b1 = 1'b1; a8 = 8'h00; b8 = 8'hFF;
    cycle("hold");
    check("hold_v1", 32'(v1), 32'd0);
    check("hold_s1", 32'(s1), 32'd0);
    check("hold_c1", 32'(c1), 32'd1);
    a1 = 1'bx; b1 = 1'bx; a8 = 'x; b8 = 'x;
    cycle("hold_x");
    check("hold_x_c8", 32'(c8), 32'hFF);

    // Async reset mid-cycle, sample during reset ignored, first edge after release accepted
    iv = 1'b1; a1 = 1'b1; b1 = 1'b0; a8 = 8'h0F; b8 = 8'h00;
    cycle("pre_rst");
    check("pre_rst_s1", 32'(s1), 32'd1);
    #20;
    rst = 1'b1;
    #1;
    model_zero();
    check("arst_s1", 32'(s1), 32'd0);
    check("arst_v1", 32'(v1), 32'd0);
    check("arst_s8", 32'(s8), 32'd0);
    cycle("in_rst");
    check("in_rst_s1", 32'(s1), 32'd0);
    rst = 1'b0;
    cycle("post_rst");
    check("post_rst_s1", 32'(s1), 32'd1);
    check("post_rst_c1", 32'(c1), 32'd0);
    check("post_rst_v1", 32'(v1), 32'd1);

    // Multi-lane independence
    a8 = 8'hF0; b8 = 8'h3C;
    cycle("lanes");
    check("lanes_s8", 32'(s8), 32'hCC);
    check("lanes_c8", 32'(c8), 32'h30);

`ifdef HALF_ADDER_STATS_EN
    // Carry statistics: accumulate, clear-wins, saturation
    iv = 1'b0; clr = 1'b1;
    cycle("st_clr");
    clr = 1'b0; iv = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    for (int i = 0; i < 3; i++) cycle("st_acc");
    check("st_cnt24", 32'(cnt8), 32'd24);
    clr = 1'b1;
    cycle("st_clr_wins");
    check("st_clr_wins", 32'(cnt8), 32'd0);
    clr = 1'b0;
    for (int i = 0; i < 40; i++) cycle("st_sat");
    check("st_sat255", 32'(cnt8), 32'd255);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      iv  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      a1  = 1'($urandom);
      b1  = 1'($urandom);
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
